// File: rtl/display_sched_if.sv
// Signal bundle between the display scheduler and its driver: second tick,
// mode button, and the view/state outputs that feed the display formatter.
interface display_sched_if;
  logic       tick_1hz;
  logic       btn_mode;
  logic       mode;
  logic [1:0] state_o;
  logic [5:0] hold_left;
  logic       mode_chg;

  modport master (
    output tick_1hz,
    output btn_mode,
    input  mode,
    input  state_o,
    input  hold_left,
    input  mode_chg
  );

  modport slave (
    input  tick_1hz,
    input  btn_mode,
    output mode,
    output state_o,
    output hold_left,
    output mode_chg
  );
endinterface

// File: rtl/display_sched.sv
// TIME/DATE view scheduler: a press shows DATE for DATE_HOLD_SEC seconds, a second
// press locks DATE, a third returns to TIME. Optional idle auto-rotate: DISPLAY_AUTO_ROTATE_EN.
module display_sched #(
  parameter int DATE_HOLD_SEC   = 5,
  parameter int AUTO_PERIOD_SEC = 30
) (
  input  logic           clk,
  input  logic           rst_n,
  display_sched_if.slave bus
);

  typedef enum logic [1:0] {
    TIME_SHOW = 2'b00,
    DATE_HOLD = 2'b01,
    DATE_LOCK = 2'b10,
    STATE_BAD = 2'b11
  } state_e;

  localparam logic [5:0] HOLD_LOAD = 6'(DATE_HOLD_SEC);

  state_e     state_q, state_d;
  logic [5:0] hold_left_q, hold_left_d;
  logic       mode_chg_q, mode_chg_d;
  logic       btn_q, btn_d;
  logic       press;

  // Rising edge of the level; btn_q resets high so a button held through reset is ignored.
  assign press = bus.btn_mode & ~btn_q;

`ifdef DISPLAY_AUTO_ROTATE_EN
  localparam logic [7:0] AUTO_LIMIT = 8'(AUTO_PERIOD_SEC);

  logic [7:0] idle_q, idle_d;
  logic [7:0] idle_inc;

  assign idle_inc = idle_q + 8'd1;
`else
  logic unused_auto_period;

  assign unused_auto_period = ^8'(AUTO_PERIOD_SEC);
`endif

  always_comb begin
    state_d     = state_q;
    hold_left_d = hold_left_q;
    btn_d       = bus.btn_mode;
`ifdef DISPLAY_AUTO_ROTATE_EN
    idle_d      = idle_q;
`endif

    case (state_q)
      TIME_SHOW: begin
        hold_left_d = '0;
        if (press) begin
          state_d     = DATE_HOLD;
          hold_left_d = HOLD_LOAD;
`ifdef DISPLAY_AUTO_ROTATE_EN
        end else if (bus.tick_1hz) begin
          if (idle_inc == AUTO_LIMIT) begin
            state_d     = DATE_HOLD;
            hold_left_d = HOLD_LOAD;
          end else begin
            idle_d = idle_inc;
          end
`endif
        end
      end

      DATE_HOLD: begin
        if (press) begin
          state_d     = DATE_LOCK;
          hold_left_d = '0;
        end else if (bus.tick_1hz) begin
          // A zero count cannot occur normally; treat it like the last second.
          if (hold_left_q <= 6'd1) begin
            state_d     = TIME_SHOW;
            hold_left_d = '0;
          end else begin
            hold_left_d = hold_left_q - 6'd1;
          end
        end
      end

      DATE_LOCK: begin
        hold_left_d = '0;
        if (press) begin
          state_d = TIME_SHOW;
        end
      end

      default: begin
        state_d     = TIME_SHOW;
        hold_left_d = '0;
      end
    endcase

`ifdef DISPLAY_AUTO_ROTATE_EN
    // Idle time only accumulates while TIME is both shown now and shown next.
    if ((state_q != TIME_SHOW) || (state_d != TIME_SHOW)) begin
      idle_d = '0;
    end
`endif

    mode_chg_d = (state_d == TIME_SHOW) != (state_q == TIME_SHOW);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= TIME_SHOW;
      hold_left_q <= '0;
      mode_chg_q  <= 1'b0;
      btn_q       <= 1'b1;
`ifdef DISPLAY_AUTO_ROTATE_EN
      idle_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      hold_left_q <= hold_left_d;
      mode_chg_q  <= mode_chg_d;
      btn_q       <= btn_d;
`ifdef DISPLAY_AUTO_ROTATE_EN
      idle_q      <= idle_d;
`endif
    end
  end

  assign bus.mode      = (state_q == TIME_SHOW);
  assign bus.state_o   = state_q;
  assign bus.hold_left = hold_left_q;
  assign bus.mode_chg  = mode_chg_q;

endmodule

// File: tb/tb_display_sched.sv
// Bench for display_sched: directed scenarios with hand-derived expectations plus
// a randomized run compared against a view-level reference model.
module tb_display_sched;

  localparam int HOLD   = 5;
  localparam int PERIOD = 30;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  display_sched_if ifc ();

  display_sched #(
    .DATE_HOLD_SEC  (HOLD),
    .AUTO_PERIOD_SEC(PERIOD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: view 0 = TIME, 1 = DATE timed, 2 = DATE locked.
  int m_view;
  int m_hold;
  int m_idle;
  bit m_prev_btn;
  bit m_chg;

  task automatic model_edge(input bit rst_v, input bit btn, input bit tick);
    bit press;
    bit was_time;
    if (!rst_v) begin
      m_view = 0; m_hold = 0; m_idle = 0; m_prev_btn = 1'b1; m_chg = 1'b0;
      return;
    end
    press      = btn && !m_prev_btn;
    m_prev_btn = btn;
    was_time   = (m_view == 0);
    if (m_view == 0) begin
      if (press) begin
        m_view = 1; m_hold = HOLD; m_idle = 0;
      end else if (tick) begin
`ifdef DISPLAY_AUTO_ROTATE_EN
        m_idle = m_idle + 1;
        if (m_idle == PERIOD) begin
          m_view = 1; m_hold = HOLD; m_idle = 0;
        end
`endif
      end
    end else if (m_view == 1) begin
      m_idle = 0;
      if (press) begin
        m_view = 2; m_hold = 0;
      end else if (tick) begin
        if (m_hold <= 1) begin
          m_view = 0; m_hold = 0;
        end else begin
          m_hold = m_hold - 1;
        end
      end
    end else begin
      m_idle = 0;
      if (press) m_view = 0;
    end
    m_chg = (was_time != (m_view == 0));
  endtask

  // Drive one cycle of inputs, let the edge happen, then sample 1 time unit later.
  task automatic step(input bit btn, input bit tick);
    ifc.btn_mode = btn;
    ifc.tick_1hz = tick;
    @(posedge clk);
    #1;
    ifc.tick_1hz = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 1'b0);
    rst_n = 1'b1;
    step(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(1'b0, 1'b0);
    checks++;
    if (ifc.state_o !== 2'b00 || ifc.mode !== 1'b1 || ifc.hold_left !== 6'd0 || ifc.mode_chg !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: state=%b mode=%b hold=%0d chg=%b, required 00 1 0 0",
               ifc.state_o, ifc.mode, ifc.hold_left, ifc.mode_chg);
    end
    rst_n = 1'b1;
    step(1'b0, 1'b0);
  endtask

  task automatic test_hold_expire();
    do_reset();
    step(1'b1, 1'b0);
    checks++;
    if (ifc.state_o !== 2'b01 || ifc.hold_left !== 6'd5 || ifc.mode !== 1'b0 || ifc.mode_chg !== 1'b1) begin
      failures++;
      $display("FAIL hold_entry: state=%b hold=%0d mode=%b chg=%b, required 01 5 0 1",
               ifc.state_o, ifc.hold_left, ifc.mode, ifc.mode_chg);
    end
    step(1'b0, 1'b0);
    checks++;
    if (ifc.mode_chg !== 1'b0) begin
      failures++;
      $display("FAIL chg_single_cycle: chg=%b, required 0", ifc.mode_chg);
    end
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 1'b1);
      checks++;
      if (ifc.state_o !== 2'b01 || ifc.hold_left !== 6'(5 - i)) begin
        failures++;
        $display("FAIL hold_count tick %0d: state=%b hold=%0d, required 01 %0d",
                 i, ifc.state_o, ifc.hold_left, 5 - i);
      end
      step(1'b0, 1'b0);
    end
    step(1'b0, 1'b1);
    checks++;
    if (ifc.state_o !== 2'b00 || ifc.hold_left !== 6'd0 || ifc.mode !== 1'b1 || ifc.mode_chg !== 1'b1) begin
      failures++;
      $display("FAIL hold_exit: state=%b hold=%0d mode=%b chg=%b, required 00 0 1 1",
               ifc.state_o, ifc.hold_left, ifc.mode, ifc.mode_chg);
    end
    step(1'b0, 1'b0);
  endtask

  task automatic test_lock();
    do_reset();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    checks++;
    if (ifc.hold_left !== 6'd3) begin
      failures++;
      $display("FAIL lock_pre_hold: hold=%0d, required 3", ifc.hold_left);
    end
    step(1'b1, 1'b0);
    checks++;
    if (ifc.state_o !== 2'b10 || ifc.hold_left !== 6'd0 || ifc.mode !== 1'b0 || ifc.mode_chg !== 1'b0) begin
      failures++;
      $display("FAIL lock_entry: state=%b hold=%0d mode=%b chg=%b, required 10 0 0 0",
               ifc.state_o, ifc.hold_left, ifc.mode, ifc.mode_chg);
    end
    step(1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
    end
    checks++;
    if (ifc.state_o !== 2'b10 || ifc.mode !== 1'b0) begin
      failures++;
      $display("FAIL lock_ignores_tick: state=%b mode=%b, required 10 0", ifc.state_o, ifc.mode);
    end
    step(1'b1, 1'b0);
    checks++;
    if (ifc.state_o !== 2'b00 || ifc.mode !== 1'b1 || ifc.mode_chg !== 1'b1) begin
      failures++;
      $display("FAIL lock_exit: state=%b mode=%b chg=%b, required 00 1 1",
               ifc.state_o, ifc.mode, ifc.mode_chg);
    end
    step(1'b0, 1'b0);
  endtask

  task automatic test_press_tick_collision();
    do_reset();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
    end
    checks++;
    if (ifc.hold_left !== 6'd1) begin
      failures++;
      $display("FAIL collision_pre_hold: hold=%0d, required 1", ifc.hold_left);
    end
    step(1'b1, 1'b1);
    checks++;
    if (ifc.state_o !== 2'b10 || ifc.hold_left !== 6'd0 || ifc.mode !== 1'b0) begin
      failures++;
      $display("FAIL collision_priority: state=%b hold=%0d mode=%b, required 10 0 0",
               ifc.state_o, ifc.hold_left, ifc.mode);
    end
    step(1'b0, 1'b0);
  endtask

  task automatic test_btn_held_reset();
    int bad;
    rst_n = 1'b0;
    step(1'b1, 1'b0);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0);
      if (ifc.state_o !== 2'b00) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL held_through_reset: %0d cycles left state 00, required 0", bad);
    end
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    checks++;
    if (ifc.state_o !== 2'b01) begin
      failures++;
      $display("FAIL press_after_release: state=%b, required 01", ifc.state_o);
    end
    step(1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    rst_n = 1'b0;
    step(1'b0, 1'b0);
    checks++;
    if (ifc.state_o !== 2'b00 || ifc.hold_left !== 6'd0 || ifc.mode !== 1'b1 || ifc.mode_chg !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_hold: state=%b hold=%0d mode=%b chg=%b, required 00 0 1 0",
               ifc.state_o, ifc.hold_left, ifc.mode, ifc.mode_chg);
    end
    rst_n = 1'b1;
    step(1'b0, 1'b1);
    checks++;
    if (ifc.state_o !== 2'b00 || ifc.hold_left !== 6'd0) begin
      failures++;
      $display("FAIL no_residual_count: state=%b hold=%0d, required 00 0", ifc.state_o, ifc.hold_left);
    end
  endtask

  task automatic test_auto_rotate();
    do_reset();
`ifdef DISPLAY_AUTO_ROTATE_EN
    for (int i = 0; i < PERIOD - 1; i++) begin
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
    end
    checks++;
    if (ifc.state_o !== 2'b00) begin
      failures++;
      $display("FAIL auto_early: state=%b after %0d ticks, required 00", ifc.state_o, PERIOD - 1);
    end
    step(1'b0, 1'b1);
    checks++;
    if (ifc.state_o !== 2'b01 || ifc.hold_left !== 6'd5 || ifc.mode_chg !== 1'b1) begin
      failures++;
      $display("FAIL auto_entry: state=%b hold=%0d chg=%b, required 01 5 1",
               ifc.state_o, ifc.hold_left, ifc.mode_chg);
    end
    step(1'b0, 1'b0);
    for (int i = 0; i < HOLD; i++) begin
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
    end
    checks++;
    if (ifc.state_o !== 2'b00 || ifc.mode !== 1'b1) begin
      failures++;
      $display("FAIL auto_hold_expire: state=%b mode=%b, required 00 1", ifc.state_o, ifc.mode);
    end
    for (int i = 0; i < PERIOD - 2; i++) begin
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
    end
    step(1'b1, 1'b1);
    checks++;
    if (ifc.state_o !== 2'b01 || ifc.hold_left !== 6'd5) begin
      failures++;
      $display("FAIL auto_press_priority: state=%b hold=%0d, required 01 5", ifc.state_o, ifc.hold_left);
    end
    step(1'b0, 1'b0);
    for (int i = 0; i < HOLD; i++) begin
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
    end
    for (int i = 0; i < PERIOD - 1; i++) begin
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
    end
    checks++;
    if (ifc.state_o !== 2'b00) begin
      failures++;
      $display("FAIL auto_restart_early: state=%b, required 00", ifc.state_o);
    end
    step(1'b0, 1'b1);
    checks++;
    if (ifc.state_o !== 2'b01) begin
      failures++;
      $display("FAIL auto_restart_entry: state=%b, required 01", ifc.state_o);
    end
    step(1'b0, 1'b0);
`else
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      checks++;
      if (ifc.mode !== 1'b1 || ifc.state_o !== 2'b00) begin
        failures++;
        $display("FAIL no_auto tick %0d: state=%b mode=%b, required 00 1", i + 1, ifc.state_o, ifc.mode);
      end
    end
`endif
  endtask

  task automatic test_random();
    bit btn;
    bit tick;
    bit rst_v;
    btn = 1'b0;
    model_edge(1'b0, 1'b0, 1'b0);
    do_reset();
    model_edge(1'b1, 1'b0, 1'b0);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ($urandom_range(0, 9) == 0) btn = ~btn;
      tick  = ($urandom_range(0, 5) == 0);
      rst_v = ($urandom_range(0, 499) != 0);
      rst_n = rst_v;
      step(btn, tick);
      model_edge(rst_v, btn, tick);
      checks++;
      if (ifc.state_o !== 2'(m_view) || ifc.mode !== (m_view == 0) ||
          ifc.hold_left !== 6'(m_hold) || ifc.mode_chg !== m_chg) begin
        failures++;
        $display("FAIL random cycle %0d: state=%b mode=%b hold=%0d chg=%b, required %0d %0d %0d %0d",
                 cyc, ifc.state_o, ifc.mode, ifc.hold_left, ifc.mode_chg,
                 m_view, (m_view == 0), m_hold, m_chg);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst_n        = 1'b0;
    ifc.btn_mode = 1'b0;
    ifc.tick_1hz = 1'b0;
    @(negedge clk);
    test_reset();
    test_hold_expire();
    test_lock();
    test_press_tick_collision();
    test_btn_held_reset();
    test_reset_mid_hold();
    test_auto_rotate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit, required completion");
    $fatal(1, "timeout");
  end

endmodule
